// File: rtl/fp_pkg.sv
// Shared single-precision helpers and FSM state encoding for the frame accumulator.
package fp_pkg;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam logic [7:0]  FP_EXP_ONES = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // NaN: all-ones exponent with a non-zero mantissa (infinity is not NaN).
  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == FP_EXP_ONES) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_accum_seq_if.sv
// Sample stream, adder handshake and frame result of fp_accum_seq in one bundle.
interface fp_accum_seq_if #(
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic             in_last;

  logic             add_start;
  logic             add_op;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_busy;
  logic             add_ready;
  logic [31:0]      add_y;

  logic             sum_valid;
  logic [31:0]      sum_data;
  logic [CNT_W-1:0] sum_cnt;
  logic             nan_flag;
  logic             err_timeout;

  // The accumulator's own view.
  modport slave (
    input  in_valid, in_data, in_sub, in_last,
    input  add_busy, add_ready, add_y,
    output in_ready,
    output add_start, add_op, add_a, add_b,
    output sum_valid, sum_data, sum_cnt, nan_flag, err_timeout
  );

  // The surrounding logic: sample source, adder and result sink.
  modport master (
    output in_valid, in_data, in_sub, in_last,
    output add_busy, add_ready, add_y,
    input  in_ready,
    input  add_start, add_op, add_a, add_b,
    input  sum_valid, sum_data, sum_cnt, nan_flag, err_timeout
  );

endinterface

// File: rtl/fp_accum_seq.sv
// Frame accumulator: folds each sample into a running sum through an external
// adder_fp, one operation per sample, and reports the frame result on the last one.
module fp_accum_seq
  import fp_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_accum_seq_if.slave  bus
);

  localparam int                TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT - 1);

  state_e             r_state;
  state_e             w_state_nxt;

  logic [31:0]        r_acc;
  logic [31:0]        r_b;
  logic               r_op;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_nan;
  logic [TMO_W-1:0]   r_tmo;

  logic [31:0]        r_sum_data;
  logic [CNT_W-1:0]   r_sum_cnt;
  logic               r_sum_nan;
  logic               r_sum_err;

  logic               w_in_ready;
  logic               w_add_start;
  logic               w_sum_valid;
  logic               w_accept;
  logic               w_take;
  logic               w_timeout;
  logic               w_clear;
  logic               w_y_nan;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_y_nan   = fp_is_nan(bus.add_y);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values; the async reset branch comes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_add_start = 1'b0;
    w_sum_valid = 1'b0;
    w_accept    = 1'b0;
    w_take      = 1'b0;
    w_timeout   = 1'b0;
    w_clear     = 1'b0;

    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end

      LAUNCH: begin
        if (!bus.add_busy) begin
          w_add_start = 1'b1;
          w_state_nxt = WAIT;
        end
      end

      // A result arriving on the final timeout cycle still wins.
      WAIT: begin
        if (bus.add_ready) begin
          w_take      = 1'b1;
          w_state_nxt = r_last ? DONE : IDLE;
        end else if (r_tmo == TMO_MAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        w_sum_valid = 1'b1;
        w_clear     = 1'b1;
        w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= FP_ZERO;
      r_b        <= FP_ZERO;
      r_op       <= 1'b0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_nan      <= 1'b0;
      r_tmo      <= '0;
      r_sum_data <= FP_ZERO;
      r_sum_cnt  <= '0;
      r_sum_nan  <= 1'b0;
      r_sum_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_b    <= bus.in_data;
        r_op   <= bus.in_sub;
        r_last <= bus.in_last;
      end

      if (w_add_start) begin
        r_tmo <= '0;
      end else if (r_state == WAIT) begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (w_take) begin
        r_acc <= bus.add_y;
        r_cnt <= w_cnt_inc;
        r_nan <= r_nan | w_y_nan;
      end

      // The frame result is loaded on the edge entering DONE so it is already
      // valid while sum_valid is high, and then held until the next frame.
      if (w_take && r_last) begin
        r_sum_data <= bus.add_y;
        r_sum_cnt  <= w_cnt_inc;
        r_sum_nan  <= r_nan | w_y_nan;
        r_sum_err  <= 1'b0;
      end else if (w_timeout) begin
        r_sum_data <= r_acc;
        r_sum_cnt  <= r_cnt;
        r_sum_nan  <= r_nan;
        r_sum_err  <= 1'b1;
      end

      if (w_clear) begin
        r_acc <= FP_ZERO;
        r_cnt <= '0;
        r_nan <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.add_start   = w_add_start;
  assign bus.add_op      = r_op;
  assign bus.add_a       = r_acc;
  assign bus.add_b       = r_b;
  assign bus.sum_valid   = w_sum_valid;
  assign bus.sum_data    = r_sum_data;
  assign bus.sum_cnt     = r_sum_cnt;
  assign bus.nan_flag    = r_sum_nan;
  assign bus.err_timeout = r_sum_err;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Scoreboard bench for fp_accum_seq: a behavioural adder_fp stands beside the DUT and
// frame results are checked against sums computed directly from the issued samples.
module tb_fp_accum_seq;

  localparam int TMO   = 16;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;

  fp_accum_seq_if #(.CNT_W(CNT_W)) ifc ();

  fp_accum_seq #(.TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] sum;
    logic        chk_sum;
    int          cnt;
    logic        nan;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single-precision <-> real conversion; denormals flush to zero, NaN is quiet.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'h00) d = {x[31], 63'd0};
    else if (x[30:23] == 8'hFF)
      d = {x[31], 11'h7FF, (x[22:0] != 23'd0) ? 52'h8_0000_0000_0000 : 52'd0};
    else d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 2047) return {d[63], 8'hFF, (d[51:0] != 52'd0) ? 23'h40_0000 : 23'd0};
    if (e == 0) return {d[63], 31'd0};
    e = e - 1023 + 127;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural adder_fp: latency lat (>=2), optional external busy and a stuck mode.
  int          lat         = 3;
  logic        force_busy  = 1'b0;
  logic        never_ready = 1'b0;
  logic        m_busy      = 1'b0;
  logic        m_ready     = 1'b0;
  logic [31:0] m_y         = 32'd0;
  logic [31:0] m_a, m_b;
  logic        m_op;
  int          m_cnt;

  assign ifc.add_busy  = m_busy | force_busy;
  assign ifc.add_ready = m_ready;
  assign ifc.add_y     = m_y;

  always @(posedge clk) begin
    if (ifc.add_start === 1'b1) begin
      m_a     <= ifc.add_a;
      m_b     <= ifc.add_b;
      m_op    <= ifc.add_op;
      m_busy  <= 1'b1;
      m_ready <= 1'b0;
      m_cnt   <= lat - 1;
    end else if (m_busy && !never_ready) begin
      if (m_cnt <= 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_y     <= r2sp(m_op ? sp2r(m_a) - sp2r(m_b) : sp2r(m_a) + sp2r(m_b));
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Monitor: every sum_valid pulse is matched against the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && ifc.sum_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sum_valid: got sum %h with no frame expected", ifc.sum_data);
      end else begin
        e = sb_q.pop_front();
        if (e.chk_sum) check("sum_data", ifc.sum_data, e.sum);
        check("sum_cnt", 32'(ifc.sum_cnt), e.cnt);
        check("nan_flag", 32'(ifc.nan_flag), 32'(e.nan));
        check("err_timeout", 32'(ifc.err_timeout), 32'(e.err));
      end
    end
  end

  task automatic push_exp(input logic [31:0] s, input logic cs, input int c,
                          input logic nan, input logic err);
    exp_t e;
    e.sum = s; e.chk_sum = cs; e.cnt = c; e.nan = nan; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic sub, input logic last);
    int budget = 0;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_sub   = sub;
    ifc.in_last  = last;
    while (ifc.in_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (ifc.in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles", ifc.in_ready, budget);
    end else begin
      @(posedge clk);
    end
    #1 ifc.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (ifc.in_ready !== 1'b1 && budget < 200);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ifc.add_start !== 1'b1 && waited < 100);
    if (ifc.add_start !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_timeout: add_start not seen in %0d cycles", waited);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},    32'(ifc.in_ready),    32'd1);
    check({tag, "_add_start"},   32'(ifc.add_start),   32'd0);
    check({tag, "_add_op"},      32'(ifc.add_op),      32'd0);
    check({tag, "_add_a"},       ifc.add_a,            32'd0);
    check({tag, "_add_b"},       ifc.add_b,            32'd0);
    check({tag, "_sum_valid"},   32'(ifc.sum_valid),   32'd0);
    check({tag, "_sum_data"},    ifc.sum_data,         32'd0);
    check({tag, "_sum_cnt"},     32'(ifc.sum_cnt),     32'd0);
    check({tag, "_nan_flag"},    32'(ifc.nan_flag),    32'd0);
    check({tag, "_err_timeout"}, 32'(ifc.err_timeout), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int w;
    int nsamp;
    int v;
    int isum;
    logic sub;

    ifc.in_valid = 1'b0;
    ifc.in_data  = 32'd0;
    ifc.in_sub   = 1'b0;
    ifc.in_last  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 6.0 + 2.5 = 8.5, with latency of the last sample to sum_valid.
    lat = 3;
    send(32'h40C0_0000, 1'b0, 1'b0);
    push_exp(32'h4108_0000, 1'b1, 2, 1'b0, 1'b0);
    send(32'h4020_0000, 1'b0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.sum_valid !== 1'b1 && n < 50);
    check("last_to_sum_valid_cycles", n, lat + 2);

    // 6.0 - 2.5 = 3.5
    send(32'h40C0_0000, 1'b0, 1'b0);
    push_exp(32'h4060_0000, 1'b1, 2, 1'b0, 1'b0);
    send(32'h4020_0000, 1'b1, 1'b1);

    // Single-sample frames; the second shows the sum restarted from +0.0.
    push_exp(32'h40C0_0000, 1'b1, 1, 1'b0, 1'b0);
    send(32'h40C0_0000, 1'b0, 1'b1);
    push_exp(32'h4020_0000, 1'b1, 1, 1'b0, 1'b0);
    send(32'h4020_0000, 1'b0, 1'b1);

    // NaN is sticky across the frame; infinity is not flagged.
    send(32'h7F80_0001, 1'b0, 1'b0);
    push_exp(32'h0, 1'b0, 2, 1'b1, 1'b0);
    send(32'h1EC2_2880, 1'b0, 1'b1);
    push_exp(32'h7F80_0000, 1'b1, 1, 1'b0, 1'b0);
    send(32'h7F80_0000, 1'b0, 1'b1);

    // Adder busy for 3 cycles: add_start held off, in_ready stays low.
    wait_idle();
    force_busy = 1'b1;
    push_exp(32'hC020_0000, 1'b1, 1, 1'b0, 1'b0);
    send(32'h4020_0000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_hold_add_start", 32'(ifc.add_start), 32'd0);
      check("busy_hold_in_ready", 32'(ifc.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 force_busy = 1'b0;
    @(negedge clk);
    check("busy_release_add_start", 32'(ifc.add_start), 32'd1);
    check("launch_add_a", ifc.add_a, 32'h0000_0000);
    check("launch_add_b", ifc.add_b, 32'h4020_0000);
    check("launch_add_op", 32'(ifc.add_op), 32'd1);

    // Timeout: the second sample never completes; sum keeps the first sample.
    wait_idle();
    send(32'h40C0_0000, 1'b0, 1'b0);
    wait_idle();
    never_ready = 1'b1;
    push_exp(32'h40C0_0000, 1'b1, 1, 1'b0, 1'b1);
    send(32'h4020_0000, 1'b0, 1'b1);
    wait_start(w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.sum_valid !== 1'b1 && n < TMO + 20);
    check("timeout_latency", n, TMO + 1);
    never_ready = 1'b0;
    repeat (lat + 4) @(negedge clk);

    // Reset in the middle of WAIT; the late adder result must be ignored.
    lat = 10;
    send(32'h40C0_0000, 1'b0, 1'b0);
    wait_start(w);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwait_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    lat = 3;
    push_exp(32'h4020_0000, 1'b1, 1, 1'b0, 1'b0);
    send(32'h4020_0000, 1'b0, 1'b1);

    // Random frames of small integers: exact in single precision.
    for (int f = 0; f < 30; f++) begin
      wait_idle();
      lat   = 2 + int'($urandom_range(3));
      nsamp = 1 + int'($urandom_range(3));
      isum  = 0;
      for (int s = 0; s < nsamp; s++) begin
        v    = int'($urandom_range(200)) - 100;
        sub  = 1'($urandom_range(1));
        isum = sub ? isum - v : isum + v;
        if (s == nsamp - 1) push_exp(r2sp(real'(isum)), 1'b1, nsamp, 1'b0, 1'b0);
        send(r2sp(real'(v)), sub, s == nsamp - 1);
      end
    end

    wait_idle();
    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
